// File: rtl/control_fsm_if.sv
// control_signals_if: control strobes from the sequencer to the datapath, and
// decode/status signals from the datapath back to the sequencer.
interface control_signals_if;
   logic       write_pc;
   logic       write_ir;
   logic       write_rd;
   logic       write_csr;
   logic       mem_read;
   logic       mem_write;
   logic       addr_sel;
   logic [1:0] rd_sel;
   logic [1:0] alu_insel1;
   logic [1:0] alu_insel2;
   logic       ialign;
   logic       invalid_inst;
   logic       invalid_csr;
   logic       mem_malign;
   logic       mem_complete_read;
   logic       mem_complete_write;
   logic [6:0] opcode;
   logic [2:0] f3;
   modport fsm (
      output write_pc, write_ir, write_rd, write_csr, mem_read, mem_write,
             addr_sel, rd_sel, alu_insel1, alu_insel2,
      input  ialign, invalid_inst, invalid_csr, mem_malign,
             mem_complete_read, mem_complete_write, opcode, f3
   );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I sequencer; Mealy outputs are forced to zero
// combinationally while rst is high so reset takes effect immediately.
module control_fsm (
   input  logic              clk,
   input  logic              rst,
   control_signals_if.fsm    ctrl,
   input  logic              branch_cond,
   output logic              retire,
   output logic              trap,
   output logic              halted
);
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] MISC   = 7'b0001111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, NEXTPC, TRAP, HALT} state_t;
   state_t state, next;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= FETCH;
      else     state <= next;

   always_comb begin
      next            = state;
      ctrl.write_pc   = 1'b0;
      ctrl.write_ir   = 1'b0;
      ctrl.write_rd   = 1'b0;
      ctrl.write_csr  = 1'b0;
      ctrl.mem_read   = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.addr_sel   = 1'b0;
      ctrl.rd_sel     = 2'd0;
      ctrl.alu_insel1 = 2'd0;
      ctrl.alu_insel2 = 2'd0;
      retire          = 1'b0;
      trap            = 1'b0;
      halted          = 1'b0;
      if (!rst)
         case (state)
            FETCH:
               if (ctrl.ialign) next = TRAP;
               else begin
                  ctrl.mem_read = 1'b1;
                  ctrl.write_ir = ctrl.mem_complete_read;
                  next          = ctrl.mem_complete_read ? DECODE : FETCH;
               end
            DECODE: next = ctrl.invalid_inst ? TRAP : EXEC;
            EXEC:
               case (ctrl.opcode)
                  OP, OP_IMM, LUI, AUIPC: begin
                     ctrl.alu_insel1 = ctrl.opcode == LUI ? 2'd2 : ctrl.opcode == AUIPC ? 2'd1 : 2'd0;
                     ctrl.alu_insel2 = ctrl.opcode == OP ? 2'd0 : 2'd1;
                     ctrl.write_rd   = 1'b1;
                     next            = NEXTPC;
                  end
                  JAL, JALR: begin
                     ctrl.alu_insel1 = ctrl.opcode == JAL ? 2'd1 : 2'd0;
                     ctrl.alu_insel2 = 2'd1;
                     ctrl.write_pc   = 1'b1;
                     ctrl.rd_sel     = 2'd2;
                     ctrl.write_rd   = 1'b1;
                     retire          = 1'b1;
                     next            = FETCH;
                  end
                  BRANCH: begin
                     ctrl.alu_insel1 = 2'd1;
                     ctrl.alu_insel2 = 2'd1;
                     ctrl.write_pc   = branch_cond;
                     retire          = branch_cond;
                     next            = branch_cond ? FETCH : NEXTPC;
                  end
                  LOAD, STORE: next = MEM;
                  MISC:        next = NEXTPC;
                  SYSTEM:
                     if (ctrl.f3 == 3'd0 || ctrl.invalid_csr) next = TRAP;
                     else begin
                        ctrl.rd_sel    = 2'd3;
                        ctrl.write_rd  = 1'b1;
                        ctrl.write_csr = 1'b1;
                        next           = NEXTPC;
                     end
                  default: next = TRAP;
               endcase
            MEM: begin
               ctrl.addr_sel   = 1'b1;
               ctrl.alu_insel2 = 2'd1;
               if (ctrl.mem_malign) next = TRAP;
               else if (ctrl.opcode == LOAD) begin
                  ctrl.mem_read = 1'b1;
                  ctrl.write_rd = ctrl.mem_complete_read;
                  ctrl.rd_sel   = ctrl.mem_complete_read ? 2'd1 : 2'd0;
                  next          = ctrl.mem_complete_read ? NEXTPC : MEM;
               end else begin
                  ctrl.mem_write = 1'b1;
                  next           = ctrl.mem_complete_write ? NEXTPC : MEM;
               end
            end
            NEXTPC: begin
               ctrl.alu_insel1 = 2'd1;
               ctrl.alu_insel2 = 2'd2;
               ctrl.write_pc   = 1'b1;
               retire          = 1'b1;
               next            = FETCH;
            end
            TRAP: begin
               trap = 1'b1;
               next = HALT;
            end
            default: halted = 1'b1;
         endcase
   end
endmodule
